xram_arb: RTL and testbench
===========================

XRAM_ARB -- requirements
Module: xram_arb

Interface
REQ-001 Parameter TIMEOUT, default 8'd200: xram_ack wait limit in cycles, counted from the first xram_stb cycle.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 cpu_addr  input  16  CPU request address.
REQ-005 cpu_data_in  input  8  CPU write data.
REQ-006 cpu_wr  input  1  CPU write (1) / read (0).
REQ-007 cpu_stb  input  1  CPU request strobe, held until cpu_ack.
REQ-008 cpu_data_out  output  8  CPU read data, valid while cpu_ack.
REQ-009 cpu_ack  output  1  CPU completion pulse.
REQ-010 dma_addr, dma_data_in, dma_wr, dma_stb, dma_data_out, dma_ack: same directions, widths and meaning as the cpu_* ports, driven by the memory-write engine's xram_* port.
REQ-011 xram_addr  output  16  address to XRAM.
REQ-012 xram_data_out  output  8  write data to XRAM.
REQ-013 xram_data_in  input  8  read data from XRAM.
REQ-014 xram_wr  output  1  XRAM write enable.
REQ-015 xram_stb  output  1  XRAM strobe.
REQ-016 xram_ack  input  1  XRAM completion, one cycle, any latency >= 0 after xram_stb.
REQ-017 busy  output  1  high in any non-IDLE state.
REQ-018 last_grant  output  1  0 = CPU, 1 = DMA; requester served last.
REQ-019 timeout_err  output  1  sticky timeout flag.
REQ-020 err_clr  input  1  clears timeout_err.

Function
REQ-021 States SHALL be IDLE (2'b00), SERVE_CPU (2'b01) and SERVE_DMA (2'b10); 2'b11 SHALL go to IDLE on the next clock.
REQ-022 IDLE behaviour: with only one stb high, the next state SHALL serve that requester; with both high, it SHALL serve the requester that is not last_grant (round-robin); with neither high, the state SHALL stay IDLE.
REQ-023 On the IDLE->SERVE transition, addr, data_in and wr of the granted requester SHALL be latched, and last_grant SHALL be updated.
REQ-024 In SERVE_x: xram_stb=1; xram_addr, xram_data_out and xram_wr SHALL come from the latched values only.
REQ-025 In SERVE_x with xram_ack=1: x_ack=1 and x_data_out=xram_data_in in the same cycle (combinational pass-through); the next state SHALL be IDLE.
REQ-026 Any ack to the non-granted requester SHALL be 0; its data_out SHALL be 8'h00.
REQ-027 Minimum access: stb seen in IDLE at cycle n -> xram_stb at n+1 -> ack no earlier than n+1; one IDLE cycle SHALL separate consecutive grants.
REQ-028 Wait counter: 8-bit, cleared in IDLE, +1 each SERVE cycle without xram_ack.
REQ-029 Counter reaching TIMEOUT-1 without ack: x_ack=1, x_data_out=8'hFF, timeout_err set, next state IDLE.
REQ-030 A requester dropping stb before its ack SHALL NOT abort the access; the access completes and ack still pulses.
REQ-031 xram_ack while in IDLE SHALL be ignored.
REQ-032 err_clr and a timeout in the same cycle: the set SHALL win.
REQ-033 When xram_stb=0: xram_addr=16'h0000, xram_data_out=8'h00, xram_wr=0.

Reset
REQ-034 On rst, the following SHALL hold from the next edge: state=IDLE, counter=0, last_grant=1 (CPU wins first tie), timeout_err=0, latched request cleared; all acks and xram_stb SHALL be 0.
REQ-035 rst during SERVE SHALL abandon the access with no ack to the requester.

Structure
REQ-036 State encodings, grant constants and the TIMEOUT default SHALL live in shared package xram_arb_pkg.
REQ-037 Wait counter and timeout compare SHALL be sub-module xram_arb_timer (clk, rst, clr, en, limit, expired).

Verification
REQ-038 CPU read, addr 16'h0100, xram_ack 3 cycles after xram_stb, data 8'hA5 -> cpu_ack for one cycle, cpu_data_out=8'hA5, dma_ack=0.
REQ-039 cpu_stb and dma_stb both high from reset, acks at zero latency -> grants alternate CPU, DMA, CPU, DMA with one IDLE cycle between grants.
REQ-040 DMA write, addr 16'h2000, data 8'h3C; dma_addr changes to 16'hFFFF during SERVE -> xram_addr stays 16'h2000 and xram_wr=1 until ack.
REQ-041 No xram_ack with TIMEOUT=4 -> dma_ack on the 4th SERVE cycle, dma_data_out=8'hFF, timeout_err=1 until err_clr.
REQ-042 rst asserted during a CPU access with xram_ack pending -> no cpu_ack, IDLE next cycle, busy=0, xram_stb=0.

Source files
------------

// File: rtl/xram_arb_pkg.sv
// Shared encodings for the XRAM arbiter: FSM states, grant ids, default wait limit.
package xram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_SERVE_CPU = 2'b01,
        ST_SERVE_DMA = 2'b10,
        ST_BAD       = 2'b11
    } state_t;

    localparam logic GRANT_CPU = 1'b0;
    localparam logic GRANT_DMA = 1'b1;

    localparam logic [7:0] TIMEOUT_DEFAULT = 8'd200;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
        logic        wr;
    } req_t;

endpackage

// File: rtl/xram_arb_if.sv
// Request/response bundle between CPU, DMA engine, XRAM and the arbiter.
// slave = arbiter side, master = requesters plus memory.
interface xram_arb_if;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data_in;
    logic        cpu_wr;
    logic        cpu_stb;
    logic [7:0]  cpu_data_out;
    logic        cpu_ack;

    logic [15:0] dma_addr;
    logic [7:0]  dma_data_in;
    logic        dma_wr;
    logic        dma_stb;
    logic [7:0]  dma_data_out;
    logic        dma_ack;

    logic [15:0] xram_addr;
    logic [7:0]  xram_data_out;
    logic [7:0]  xram_data_in;
    logic        xram_wr;
    logic        xram_stb;
    logic        xram_ack;

    modport slave (
        input  cpu_addr, cpu_data_in, cpu_wr, cpu_stb,
        input  dma_addr, dma_data_in, dma_wr, dma_stb,
        input  xram_data_in, xram_ack,
        output cpu_data_out, cpu_ack, dma_data_out, dma_ack,
        output xram_addr, xram_data_out, xram_wr, xram_stb
    );

    modport master (
        output cpu_addr, cpu_data_in, cpu_wr, cpu_stb,
        output dma_addr, dma_data_in, dma_wr, dma_stb,
        output xram_data_in, xram_ack,
        input  cpu_data_out, cpu_ack, dma_data_out, dma_ack,
        input  xram_addr, xram_data_out, xram_wr, xram_stb
    );
endinterface

// File: rtl/xram_arb_timer.sv
// XRAM wait counter: counts unacknowledged serve cycles, flags the last allowed one.
// expired is combinational from the count; clr has priority over en.
module xram_arb_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] limit,
    output logic       expired
);
    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 8'd1;
        end
    end

    assign expired = (count == limit - 8'd1);
endmodule

// File: rtl/xram_arb.sv
// Round-robin arbiter of CPU and DMA onto one XRAM port; grant one cycle after stb, ack passed through same cycle.
// Requesters wait by holding stb; a stuck XRAM is cut off after TIMEOUT serve cycles with 8'hFF data.
module xram_arb
    import xram_arb_pkg::*;
#(
    parameter logic [7:0] TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic      clk,
    input  logic      rst,
    xram_arb_if.slave bus,
    input  logic      err_clr,
    output logic      busy,
    output logic      last_grant,
    output logic      timeout_err
);
    state_t     state, state_d;
    req_t       req_q, req_d;
    logic       grant_d;
    logic       serving;
    logic       expired;
    logic       finish;
    logic       timeout_hit;
    logic [7:0] rsp_data;

    assign serving     = (state == ST_SERVE_CPU) || (state == ST_SERVE_DMA);
    assign busy        = (state != ST_IDLE);
    // Abandoned accesses under reset must not ack even if XRAM answers.
    assign finish      = serving && !rst && (bus.xram_ack || expired);
    assign timeout_hit = finish && !bus.xram_ack;
    assign rsp_data    = bus.xram_ack ? bus.xram_data_in : 8'hFF;

    always_comb begin
        state_d = state;
        req_d   = req_q;
        grant_d = last_grant;
        case (state)
            ST_IDLE: begin
                if (bus.cpu_stb && (!bus.dma_stb || last_grant == GRANT_DMA)) begin
                    state_d = ST_SERVE_CPU;
                    grant_d = GRANT_CPU;
                    req_d   = {bus.cpu_addr, bus.cpu_data_in, bus.cpu_wr};
                end else if (bus.dma_stb) begin
                    state_d = ST_SERVE_DMA;
                    grant_d = GRANT_DMA;
                    req_d   = {bus.dma_addr, bus.dma_data_in, bus.dma_wr};
                end
            end
            ST_SERVE_CPU, ST_SERVE_DMA: begin
                if (finish) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            req_q       <= '0;
            last_grant  <= GRANT_DMA;
            timeout_err <= 1'b0;
        end else begin
            state      <= state_d;
            req_q      <= req_d;
            last_grant <= grant_d;
            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end else if (err_clr) begin
                timeout_err <= 1'b0;
            end
        end
    end

    xram_arb_timer u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (!serving),
        .en      (serving && !bus.xram_ack),
        .limit   (TIMEOUT),
        .expired (expired)
    );

    assign bus.cpu_ack      = finish && (state == ST_SERVE_CPU);
    assign bus.dma_ack      = finish && (state == ST_SERVE_DMA);
    assign bus.cpu_data_out = bus.cpu_ack ? rsp_data : 8'h00;
    assign bus.dma_data_out = bus.dma_ack ? rsp_data : 8'h00;

    assign bus.xram_stb      = serving;
    assign bus.xram_addr     = serving ? req_q.addr : 16'h0000;
    assign bus.xram_data_out = serving ? req_q.data : 8'h00;
    assign bus.xram_wr       = serving && req_q.wr;
endmodule

// File: tb/tb_xram_arb.sv
// Bench for xram_arb: directed scenarios plus a randomized run against a transaction-level model.
module tb_xram_arb;
    import xram_arb_pkg::*;

    localparam logic [7:0] TO_SHORT = 8'd4;

    logic clk = 1'b0;
    logic rst;
    logic err_clr, busy, last_grant, timeout_err;
    logic err_clr_to, busy_to, last_grant_to, timeout_err_to;

    xram_arb_if bus ();
    xram_arb_if bus_to ();

    xram_arb dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .err_clr     (err_clr),
        .busy        (busy),
        .last_grant  (last_grant),
        .timeout_err (timeout_err)
    );

    xram_arb #(.TIMEOUT(TO_SHORT)) dut_to (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus_to),
        .err_clr     (err_clr_to),
        .busy        (busy_to),
        .last_grant  (last_grant_to),
        .timeout_err (timeout_err_to)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] xbus_v();
        return {6'b0, bus.xram_stb, bus.xram_wr, bus.xram_addr, bus.xram_data_out};
    endfunction
    function automatic logic [31:0] cresp_v();
        return {23'b0, bus.cpu_ack, bus.cpu_data_out};
    endfunction
    function automatic logic [31:0] dresp_v();
        return {23'b0, bus.dma_ack, bus.dma_data_out};
    endfunction
    function automatic logic [31:0] status_v();
        return {29'b0, busy, last_grant, timeout_err};
    endfunction
    function automatic logic [31:0] dresp_to_v();
        return {23'b0, bus_to.dma_ack, bus_to.dma_data_out};
    endfunction
    function automatic logic [31:0] status_to_v();
        return {29'b0, busy_to, last_grant_to, timeout_err_to};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cpu_addr = '0; bus.cpu_data_in = '0; bus.cpu_wr = 1'b0; bus.cpu_stb = 1'b0;
        bus.dma_addr = '0; bus.dma_data_in = '0; bus.dma_wr = 1'b0; bus.dma_stb = 1'b0;
        bus.xram_data_in = '0; bus.xram_ack = 1'b0;
        bus_to.cpu_addr = '0; bus_to.cpu_data_in = '0; bus_to.cpu_wr = 1'b0; bus_to.cpu_stb = 1'b0;
        bus_to.dma_addr = '0; bus_to.dma_data_in = '0; bus_to.dma_wr = 1'b0; bus_to.dma_stb = 1'b0;
        bus_to.xram_data_in = '0; bus_to.xram_ack = 1'b0;
        err_clr = 1'b0;
        err_clr_to = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        rst = 1'b0;
    endtask

    // Reference model: who currently owns XRAM, the request it latched, and
    // how long the simulated memory will take to answer.
    int          owner;
    int          served;
    int          lat;
    int          pick;
    logic [15:0] l_addr;
    logic [7:0]  l_data;
    logic        l_wr;
    logic        m_last, m_err;
    logic [7:0]  mem [16];
    logic        act [2];
    logic        drop [2];
    logic [15:0] r_addr [2];
    logic [7:0]  r_data [2];
    logic        r_wr [2];
    logic        x_ack, rst_now, fin;
    logic [7:0]  x_dat;
    logic [31:0] e_x, e_c, e_d, e_s;

    initial begin
        do_reset();

        // Reset state
        @(negedge clk);
        chk("rst_status", status_v(), 32'b010);
        chk("rst_xbus", xbus_v(), 32'h0);
        chk("rst_cpu_rsp", cresp_v(), 32'h0);
        chk("rst_dma_rsp", dresp_v(), 32'h0);
        chk("rst_status_to", status_to_v(), 32'b010);
        step();

        // CPU read, ack three cycles after xram_stb
        bus.cpu_addr = 16'h0100; bus.cpu_data_in = 8'h00; bus.cpu_wr = 1'b0; bus.cpu_stb = 1'b1;
        @(negedge clk);
        chk("rd_idle_xbus", xbus_v(), 32'h0);
        step();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rd_wait_xbus", xbus_v(), {6'b0, 1'b1, 1'b0, 16'h0100, 8'h00});
            chk("rd_wait_cpu_rsp", cresp_v(), 32'h0);
            step();
        end
        bus.xram_ack = 1'b1; bus.xram_data_in = 8'hA5;
        @(negedge clk);
        chk("rd_cpu_rsp", cresp_v(), 32'h1A5);
        chk("rd_dma_rsp", dresp_v(), 32'h0);
        step();
        bus.xram_ack = 1'b0; bus.cpu_stb = 1'b0;
        @(negedge clk);
        chk("rd_ack_pulse", cresp_v(), 32'h0);
        chk("rd_status_after", status_v(), 32'b000);

        // Both requesters from reset, zero-latency memory: CPU, DMA, CPU, DMA with idle gaps
        do_reset();
        bus.cpu_addr = 16'h0011; bus.dma_addr = 16'h0022;
        bus.cpu_stb = 1'b1; bus.dma_stb = 1'b1;
        bus.xram_ack = 1'b1; bus.xram_data_in = 8'h5A;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("rr_grant", {30'b0, bus.cpu_ack, bus.dma_ack}, (i % 2 == 0) ? 0 : ((i % 4 == 1) ? 2 : 1));
            step();
        end
        idle_inputs();

        // DMA write: later changes to dma_* must not reach XRAM
        bus.dma_addr = 16'h2000; bus.dma_data_in = 8'h3C; bus.dma_wr = 1'b1; bus.dma_stb = 1'b1;
        @(negedge clk);
        chk("wr_idle_xbus", xbus_v(), 32'h0);
        step();
        bus.dma_addr = 16'hFFFF; bus.dma_data_in = 8'h00; bus.dma_wr = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("wr_latched_xbus", xbus_v(), {6'b0, 1'b1, 1'b1, 16'h2000, 8'h3C});
            step();
        end
        bus.xram_ack = 1'b1; bus.xram_data_in = 8'hEE;
        @(negedge clk);
        chk("wr_ack_xbus", xbus_v(), {6'b0, 1'b1, 1'b1, 16'h2000, 8'h3C});
        chk("wr_dma_rsp", dresp_v(), 32'h1EE);
        chk("wr_cpu_quiet", cresp_v(), 32'h0);
        step();
        idle_inputs();
        @(negedge clk);
        chk("wr_bus_idle", xbus_v(), 32'h0);
        step();

        // Reset in the middle of a CPU access
        bus.cpu_addr = 16'h1234; bus.cpu_data_in = 8'h99; bus.cpu_wr = 1'b1; bus.cpu_stb = 1'b1;
        step();
        @(negedge clk);
        chk("rstmid_busy", status_v(), 32'b100);
        step();
        rst = 1'b1; bus.xram_ack = 1'b1; bus.xram_data_in = 8'h11;
        @(negedge clk);
        chk("rstmid_no_ack", cresp_v(), 32'h0);
        step();
        rst = 1'b0; bus.cpu_stb = 1'b0;
        @(negedge clk);
        chk("rstmid_status", status_v(), 32'b010);
        chk("rstmid_xbus", xbus_v(), 32'h0);
        chk("rstmid_cpu_rsp", cresp_v(), 32'h0);
        step();
        idle_inputs();

        // Timeout with TIMEOUT=4: fourth serve cycle returns 8'hFF and sets the sticky flag
        bus_to.dma_addr = 16'h0042; bus_to.dma_stb = 1'b1;
        @(negedge clk);
        chk("to_idle_rsp", dresp_to_v(), 32'h0);
        step();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("to_wait_rsp", dresp_to_v(), 32'h0);
            step();
        end
        @(negedge clk);
        chk("to_rsp", dresp_to_v(), 32'h1FF);
        chk("to_status_serve", status_to_v(), 32'b110);
        step();
        bus_to.dma_stb = 1'b0;
        @(negedge clk);
        chk("to_err_set", status_to_v(), 32'b011);
        step();
        @(negedge clk);
        chk("to_err_sticky", status_to_v(), 32'b011);
        err_clr_to = 1'b1;
        step();
        err_clr_to = 1'b0;
        @(negedge clk);
        chk("to_err_clr", status_to_v(), 32'b010);

        // Timeout while err_clr is held, with stb dropped right after grant
        err_clr_to = 1'b1; bus_to.dma_stb = 1'b1;
        step();
        bus_to.dma_stb = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("to2_wait_rsp", dresp_to_v(), 32'h0);
            step();
        end
        @(negedge clk);
        chk("to2_rsp", dresp_to_v(), 32'h1FF);
        step();
        @(negedge clk);
        chk("to2_set_wins", status_to_v(), 32'b011);
        step();
        @(negedge clk);
        chk("to2_cleared", status_to_v(), 32'b010);
        step();
        idle_inputs();

        // Randomized traffic against the model
        do_reset();
        owner = -1; served = 0; lat = 0; m_last = 1'b1; m_err = 1'b0;
        l_addr = '0; l_data = '0; l_wr = 1'b0;
        for (int k = 0; k < 16; k++) mem[k] = '0;
        for (int r = 0; r < 2; r++) begin
            act[r] = 1'b0; drop[r] = 1'b0; r_addr[r] = '0; r_data[r] = '0; r_wr[r] = 1'b0;
        end
        for (int cyc = 0; cyc < 2000; cyc++) begin
            rst_now = ($urandom_range(0, 299) == 0);
            for (int r = 0; r < 2; r++) begin
                if (!act[r] && $urandom_range(0, 2) == 0) begin
                    act[r] = 1'b1; drop[r] = 1'b0;
                    r_addr[r] = {8'($urandom), 4'h0, 4'($urandom_range(0, 15))};
                    r_data[r] = 8'($urandom);
                    r_wr[r]   = 1'($urandom);
                end else if (act[r] && owner == r) begin
                    if ($urandom_range(0, 7) == 0) drop[r] = 1'b1;
                    r_addr[r] = 16'($urandom);
                    r_data[r] = 8'($urandom);
                    r_wr[r]   = 1'($urandom);
                end
            end
            bus.cpu_addr = r_addr[0]; bus.cpu_data_in = r_data[0]; bus.cpu_wr = r_wr[0];
            bus.cpu_stb  = act[0] && !drop[0];
            bus.dma_addr = r_addr[1]; bus.dma_data_in = r_data[1]; bus.dma_wr = r_wr[1];
            bus.dma_stb  = act[1] && !drop[1];
            if (owner >= 0) begin
                x_ack = (served == lat);
                x_dat = (x_ack && !l_wr) ? mem[l_addr[3:0]] : 8'($urandom);
            end else begin
                x_ack = ($urandom_range(0, 5) == 0);
                x_dat = 8'($urandom);
            end
            bus.xram_ack = x_ack; bus.xram_data_in = x_dat;
            err_clr = ($urandom_range(0, 9) == 0);
            rst = rst_now;

            @(negedge clk);
            fin = (owner >= 0) && !rst_now && (x_ack || served == int'(TIMEOUT_DEFAULT) - 1);
            e_x = (owner >= 0) ? {6'b0, 1'b1, l_wr, l_addr, l_data} : 32'h0;
            e_c = (fin && owner == 0) ? 32'({1'b1, x_ack ? x_dat : 8'hFF}) : 32'h0;
            e_d = (fin && owner == 1) ? 32'({1'b1, x_ack ? x_dat : 8'hFF}) : 32'h0;
            e_s = {29'b0, owner >= 0, m_last, m_err};
            chk("rnd_xbus", xbus_v(), e_x);
            chk("rnd_cpu_rsp", cresp_v(), e_c);
            chk("rnd_dma_rsp", dresp_v(), e_d);
            chk("rnd_status", status_v(), e_s);

            if (rst_now) begin
                owner = -1; served = 0; m_last = 1'b1; m_err = 1'b0;
                for (int r = 0; r < 2; r++) begin act[r] = 1'b0; drop[r] = 1'b0; end
            end else begin
                if (fin && !x_ack) m_err = 1'b1;
                else if (err_clr) m_err = 1'b0;
                if (owner < 0) begin
                    pick = -1;
                    if (bus.cpu_stb && (!bus.dma_stb || m_last)) pick = 0;
                    else if (bus.dma_stb) pick = 1;
                    if (pick >= 0) begin
                        owner = pick; served = 0; lat = $urandom_range(0, 6);
                        l_addr = r_addr[pick]; l_data = r_data[pick]; l_wr = r_wr[pick];
                        m_last = (pick == 1);
                    end
                end else if (fin) begin
                    if (x_ack && l_wr) mem[l_addr[3:0]] = l_data;
                    act[owner] = 1'b0; drop[owner] = 1'b0;
                    owner = -1;
                end else begin
                    served++;
                end
            end
            step();
        end
        rst = 1'b0;
        idle_inputs();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
